// File: rtl/blinking_led_ctrl_pkg.sv
// Shared types and constants for the LED controller: mode encoding, heartbeat pattern, sizing helper.
package blink_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_HB    = 2'b11
    } mode_t;

    // Bit i is the LED level during heartbeat slot i.
    localparam logic [7:0] HB_PATTERN = 8'b0000_0101;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic mode_init_led(input mode_t m);
        return (m == MODE_ON) || (m == MODE_HB);
    endfunction

endpackage

// File: rtl/blinking_led_ctrl_if.sv
// Control/drive bundle between the board logic and the LED controller.
interface blinking_led_ctrl_if;
    import blink_pkg::*;

    logic  en;
    mode_t mode;
    logic  led;
    logic  tick;

    modport master (output en, output mode, input led, input tick);
    modport slave  (input en, input mode, output led, output tick);
endinterface

// File: rtl/blinking_led_ctrl_counter.sv
// Free-running 0..N-1 counter with synchronous clear; wrap flags the terminal count.
module terminal_counter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    assign wrap = (cnt == W'(N - 1));

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= wrap ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/blinking_led_ctrl.sv
// LED driver: OFF / ON / BLINK / HEARTBEAT from a divided clock, registered led and wrap tick.
module blinking_led_ctrl
    import blink_pkg::*;
#(
    parameter int HALF_PERIOD_CYCLES = 50_000_000,
    parameter int HB_SLOT_CYCLES     = 12_500_000
) (
    input  logic                clk,
    input  logic                rst_n,
    blinking_led_ctrl_if.slave  bus
);

    localparam int CNT_W = $clog2(max_int(HALF_PERIOD_CYCLES, HB_SLOT_CYCLES));

    mode_t      mode_q;
    logic [2:0] slot;
    logic [2:0] next_slot;
    logic       led_q;
    logic       tick_q;
    logic       mode_chg;
    logic       blink_clr;
    logic       hb_clr;
    logic       blink_wrap;
    logic       hb_wrap;

    assign mode_chg  = (bus.mode != mode_q);
    assign next_slot = slot + 3'd1;
    assign blink_clr = !rst_n || !bus.en || mode_chg || (bus.mode != MODE_BLINK);
    assign hb_clr    = !rst_n || !bus.en || mode_chg || (bus.mode != MODE_HB);

    terminal_counter #(
        .N (HALF_PERIOD_CYCLES),
        .W (CNT_W)
    ) u_blink_cnt (
        .clk  (clk),
        .clr  (blink_clr),
        .inc  (1'b1),
        .cnt  (),
        .wrap (blink_wrap)
    );

    terminal_counter #(
        .N (HB_SLOT_CYCLES),
        .W (CNT_W)
    ) u_hb_cnt (
        .clk  (clk),
        .clr  (hb_clr),
        .inc  (1'b1),
        .cnt  (),
        .wrap (hb_wrap)
    );

    // Reset and en=0 park mode_q at BLINK: that idle state (led=0, cnt=0) is
    // exactly BLINK's start state, so BLINK counts from the first live edge
    // while every other mode is seen as a change and loads its initial level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q <= MODE_BLINK;
            slot   <= '0;
            led_q  <= 1'b0;
            tick_q <= 1'b0;
        end else if (!bus.en) begin
            mode_q <= MODE_BLINK;
            slot   <= '0;
            led_q  <= 1'b0;
            tick_q <= 1'b0;
        end else if (mode_chg) begin
            mode_q <= bus.mode;
            slot   <= '0;
            led_q  <= mode_init_led(bus.mode);
            tick_q <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            unique case (bus.mode)
                MODE_OFF: led_q <= 1'b0;
                MODE_ON:  led_q <= 1'b1;
                MODE_BLINK: begin
                    if (blink_wrap) begin
                        led_q  <= ~led_q;
                        tick_q <= 1'b1;
                    end
                end
                MODE_HB: begin
                    if (hb_wrap) begin
                        slot   <= next_slot;
                        led_q  <= HB_PATTERN[next_slot];
                        tick_q <= 1'b1;
                    end
                end
                default: led_q <= 1'b0;
            endcase
        end
    end

    assign bus.led  = led_q;
    assign bus.tick = tick_q;

endmodule

// File: tb/tb_blinking_led_ctrl.sv
// Directed bench for blinking_led_ctrl with HALF_PERIOD_CYCLES=4, HB_SLOT_CYCLES=2.
module tb_blinking_led_ctrl;
    import blink_pkg::*;

    localparam int HALF = 4;
    localparam int SLOT = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] pat;

    always #5 clk = ~clk;

    blinking_led_ctrl_if bus ();

    blinking_led_ctrl #(
        .HALF_PERIOD_CYCLES (HALF),
        .HB_SLOT_CYCLES     (SLOT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic  r;
        logic  e;
        mode_t m;
        logic  el;
        logic  et;
    } vec_t;

    vec_t tbl [9];

    task automatic cmp(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b, expected %0b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive inputs, take one edge, then sample outputs 1 ns after it.
    task automatic step_chk(input logic r, input logic e, input mode_t m,
                            input logic el, input logic et, input string name);
        rst_n    = r;
        bus.en   = e;
        bus.mode = m;
        @(posedge clk);
        #1;
        cmp({name, " led"}, bus.led, el);
        cmp({name, " tick"}, bus.tick, et);
    endtask

    // k counts edges since BLINK's start state (k=0 is the load/reset edge).
    task automatic blink_run(input int first, input int last, input string name);
        for (int k = first; k <= last; k++) begin
            step_chk(1'b1, 1'b1, MODE_BLINK, logic'((k / HALF) % 2),
                     (k > 0) && (k % HALF == 0), $sformatf("%s k=%0d", name, k));
        end
    endtask

    // m counts edges since the heartbeat load edge (m=0).
    task automatic hb_run(input int first, input int last, input string name);
        for (int m = first; m <= last; m++) begin
            step_chk(1'b1, 1'b1, MODE_HB, pat[(m / SLOT) % 8],
                     (m > 0) && (m % SLOT == 0), $sformatf("%s m=%0d", name, m));
        end
    endtask

    initial begin
        pat      = 8'b0000_0101;
        rst_n    = 1'b0;
        bus.en   = 1'b1;
        bus.mode = MODE_ON;

        // {rst_n, en, mode, expected led, expected tick}
        tbl[0] = '{1'b0, 1'b1, MODE_ON,    1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, MODE_ON,    1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, MODE_ON,    1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b1, MODE_ON,    1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b1, MODE_ON,    1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b1, MODE_OFF,   1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b0, MODE_ON,    1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b1, MODE_ON,    1'b1, 1'b0};
        tbl[8] = '{1'b0, 1'b1, MODE_BLINK, 1'b0, 1'b0};

        for (int i = 0; i < 9; i++) begin
            step_chk(tbl[i].r, tbl[i].e, tbl[i].m, tbl[i].el, tbl[i].et,
                     $sformatf("vec%0d", i));
        end

        // BLINK straight out of reset: first rise on edge 4, 8 toggles.
        blink_run(1, 8 * HALF, "blink");

        // Heartbeat: two full 16-cycle patterns plus the wrap back to slot 0.
        hb_run(0, 16 * SLOT, "hb");

        // Mode switch mid-count: reach led=1 with cnt=2, then OFF, then BLINK again.
        blink_run(0, HALF + 2, "pre_off");
        step_chk(1'b1, 1'b1, MODE_OFF, 1'b0, 1'b0, "to_off");
        step_chk(1'b1, 1'b1, MODE_OFF, 1'b0, 1'b0, "hold_off");
        blink_run(0, HALF, "reblink");

        // Enable drop during heartbeat slot 2, then restart from slot 0.
        hb_run(0, 2 * SLOT, "hb_pre_en");
        step_chk(1'b1, 1'b0, MODE_HB, 1'b0, 1'b0, "en_drop");
        step_chk(1'b1, 1'b0, MODE_HB, 1'b0, 1'b0, "en_low");
        hb_run(0, SLOT, "hb_en_up");

        // Reset exactly when BLINK would toggle: no toggle, clean restart.
        blink_run(0, HALF - 1, "pre_rst");
        step_chk(1'b0, 1'b1, MODE_BLINK, 1'b0, 1'b0, "rst_mid");
        blink_run(1, HALF, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
